// File: rtl/bypass_scoreboard.sv
// Operand-bypass and decode hazard unit: a shift-register scoreboard of in-flight writes.
// Define BYPASS_STATS_EN to add the stall / forward statistics counters.
module bypass_scoreboard #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned NUM_STAGES = 3,
   parameter int unsigned NUM_READ   = 2,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned LAT_W      = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         dec_valid,
   input  logic [REG_AW-1:0]            dec_rd,
   input  logic                         dec_wen,
   input  logic [LAT_W-1:0]             dec_lat,
   input  logic [NUM_READ*REG_AW-1:0]   dec_rs_addr,
   input  logic [NUM_READ*XLEN-1:0]     rf_rs_data,
   input  logic [NUM_STAGES*XLEN-1:0]   stage_data,
   input  logic                         freeze,
   input  logic                         flush,
   input  logic                         dec_kill,
   output logic                         dec_stall,
   output logic [NUM_READ*XLEN-1:0]     op_data,
   output logic [NUM_READ-1:0]          fwd_hit
`ifdef BYPASS_STATS_EN
   ,
   output logic [31:0]                  stat_stall_cnt,
   output logic [31:0]                  stat_fwd_cnt
`endif
);

   logic                vld_q [NUM_STAGES];
   logic [REG_AW-1:0]   rd_q  [NUM_STAGES];
   logic [LAT_W-1:0]    lat_q [NUM_STAGES];

   logic [NUM_READ-1:0] hazard;
   logic                issue_wr;

   // Scan oldest to youngest so the youngest matching entry has the final say.
   always_comb begin
      hazard  = '0;
      fwd_hit = '0;
      op_data = rf_rs_data;
      for (int p = 0; p < int'(NUM_READ); p++) begin
         for (int s = int'(NUM_STAGES) - 1; s >= 0; s--) begin
            if (vld_q[s] && (rd_q[s] == dec_rs_addr[p*REG_AW +: REG_AW]) &&
                (dec_rs_addr[p*REG_AW +: REG_AW] != '0)) begin
               if (lat_q[s] <= LAT_W'(s)) begin
                  fwd_hit[p]               = 1'b1;
                  hazard[p]                = 1'b0;
                  op_data[p*XLEN +: XLEN]  = stage_data[s*XLEN +: XLEN];
               end else begin
                  fwd_hit[p]               = 1'b0;
                  hazard[p]                = 1'b1;
                  op_data[p*XLEN +: XLEN]  = rf_rs_data[p*XLEN +: XLEN];
               end
            end
         end
      end
   end

   assign dec_stall = dec_valid && !dec_kill && (|hazard);
   assign issue_wr  = dec_valid && dec_wen && (dec_rd != '0) && !dec_kill && !dec_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < int'(NUM_STAGES); s++) begin
            vld_q[s] <= 1'b0;
            rd_q[s]  <= '0;
            lat_q[s] <= '0;
         end
      end else if (flush) begin
         for (int s = 0; s < int'(NUM_STAGES); s++) begin
            vld_q[s] <= 1'b0;
         end
      end else if (!freeze) begin
         for (int s = 1; s < int'(NUM_STAGES); s++) begin
            vld_q[s] <= vld_q[s-1];
            rd_q[s]  <= rd_q[s-1];
            lat_q[s] <= lat_q[s-1];
         end
         vld_q[0] <= issue_wr;
         rd_q[0]  <= dec_rd;
         lat_q[0] <= dec_lat;
      end
   end

`ifdef BYPASS_STATS_EN
   logic [31:0] fwd_pop;

   always_comb begin
      fwd_pop = '0;
      for (int p = 0; p < int'(NUM_READ); p++) begin
         fwd_pop = fwd_pop + 32'(fwd_hit[p]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_stall_cnt <= '0;
         stat_fwd_cnt   <= '0;
      end else if (!freeze) begin
         if (dec_stall) begin
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
         end else if (dec_valid) begin
            stat_fwd_cnt <= stat_fwd_cnt + fwd_pop;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Self-checking bench for bypass_scoreboard: directed scenarios plus randomized traffic
// against a queue-based reference model of in-flight writes.
module tb_bypass_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        dec_valid;
   logic [4:0]  dec_rd;
   logic        dec_wen;
   logic [1:0]  dec_lat;
   logic [9:0]  dec_rs_addr;
   logic [63:0] rf_rs_data;
   logic [95:0] stage_data;
   logic        freeze;
   logic        flush;
   logic        dec_kill;
   logic        dec_stall;
   logic [63:0] op_data;
   logic [1:0]  fwd_hit;
`ifdef BYPASS_STATS_EN
   logic [31:0] stat_stall_cnt;
   logic [31:0] stat_fwd_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   bypass_scoreboard dut (
      .clk         (clk),
      .rst         (rst),
      .dec_valid   (dec_valid),
      .dec_rd      (dec_rd),
      .dec_wen     (dec_wen),
      .dec_lat     (dec_lat),
      .dec_rs_addr (dec_rs_addr),
      .rf_rs_data  (rf_rs_data),
      .stage_data  (stage_data),
      .freeze      (freeze),
      .flush       (flush),
      .dec_kill    (dec_kill),
      .dec_stall   (dec_stall),
      .op_data     (op_data),
      .fwd_hit     (fwd_hit)
`ifdef BYPASS_STATS_EN
      ,
      .stat_stall_cnt (stat_stall_cnt),
      .stat_fwd_cnt   (stat_fwd_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: list of issue slots, youngest first; index equals stage.
   typedef struct {
      bit       vld;
      bit [4:0] rd;
      int       lat;
   } slot_t;

   slot_t hist[$];
   int    m_stall_cnt;
   int    m_fwd_cnt;

   task automatic model_reset();
      slot_t b;
      b.vld = 0; b.rd = 0; b.lat = 0;
      hist.delete();
      for (int i = 0; i < 3; i++) hist.push_back(b);
      m_stall_cnt = 0;
      m_fwd_cnt   = 0;
   endtask

   task automatic model_eval(output logic stall, output logic [1:0] hit, output logic [63:0] data);
      bit       haz;
      bit [4:0] rs;
      haz  = 0;
      hit  = 2'b00;
      data = rf_rs_data;
      for (int p = 0; p < 2; p++) begin
         rs = dec_rs_addr[p*5 +: 5];
         if (rs != 0) begin
            for (int i = 0; i < hist.size(); i++) begin
               if (hist[i].vld && hist[i].rd == rs) begin
                  if (hist[i].lat <= i) begin
                     hit[p] = 1'b1;
                     data[p*32 +: 32] = stage_data[i*32 +: 32];
                  end else begin
                     haz = 1;
                  end
                  break;
               end
            end
         end
      end
      stall = dec_valid && !dec_kill && haz;
   endtask

   task automatic model_advance();
      logic        st;
      logic [1:0]  h;
      logic [63:0] d;
      slot_t       e;
      model_eval(st, h, d);
      if (!freeze) begin
         if (st) m_stall_cnt++;
         else if (dec_valid) m_fwd_cnt += $countones(h);
      end
      if (flush) begin
         for (int i = 0; i < hist.size(); i++) hist[i].vld = 0;
      end else if (!freeze) begin
         e.vld = dec_valid && dec_wen && dec_rd != 0 && !dec_kill && !st;
         e.rd  = dec_rd;
         e.lat = int'(dec_lat);
         hist.push_front(e);
         void'(hist.pop_back());
      end
   endtask

   // Advance model and DUT by one clock; returns 1 time unit after the edge.
   task automatic tick();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dec_valid   = 0;
      dec_rd      = 0;
      dec_wen     = 0;
      dec_lat     = 0;
      dec_rs_addr = 0;
      dec_kill    = 0;
      freeze      = 0;
      flush       = 0;
      rf_rs_data  = {$urandom, $urandom};
      stage_data  = {$urandom, $urandom, $urandom};
   endtask

   task automatic issue(input logic [4:0] rd, input logic [1:0] lat);
      idle();
      dec_valid = 1; dec_wen = 1; dec_rd = rd; dec_lat = lat;
   endtask

   task automatic clean();
      idle();
      flush = 1;
      tick();
      flush = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      dec_valid = 1;
      dec_rs_addr = {5'd3, 5'd5};
      #2;
      n_cmp++;
      if (dec_stall !== 1'b0 || fwd_hit !== 2'b00 || op_data !== rf_rs_data) begin
         n_err++;
         $display("FAIL reset_hold: stall=%b hit=%b data=%h want 0 00 %h",
                  dec_stall, fwd_hit, op_data, rf_rs_data);
      end
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      tick();
      n_cmp++;
      if (dec_stall !== 1'b0 || fwd_hit !== 2'b00 || op_data !== rf_rs_data) begin
         n_err++;
         $display("FAIL reset_after: stall=%b hit=%b data=%h want 0 00 %h",
                  dec_stall, fwd_hit, op_data, rf_rs_data);
      end
   endtask

   task automatic test_alu_b2b();
      issue(5'd5, 2'd0);
      tick();
      idle();
      dec_valid = 1;
      dec_rs_addr = {5'd0, 5'd5};
      stage_data[31:0] = 32'h1234;
      #1;
      n_cmp++;
      if (op_data[31:0] !== 32'h1234 || fwd_hit !== 2'b01 || dec_stall !== 1'b0) begin
         n_err++;
         $display("FAIL alu_b2b: data0=%h hit=%b stall=%b want 1234 01 0",
                  op_data[31:0], fwd_hit, dec_stall);
      end
      tick();
      clean();
   endtask

   task automatic test_load_use();
      issue(5'd7, 2'd1);
      tick();
      idle();
      dec_valid = 1;
      dec_rs_addr = {5'd7, 5'd0};
      #1;
      n_cmp++;
      if (dec_stall !== 1'b1 || fwd_hit !== 2'b00) begin
         n_err++;
         $display("FAIL load_use_stall: stall=%b hit=%b want 1 00", dec_stall, fwd_hit);
      end
      tick();
      n_cmp++;
      if (dec_stall !== 1'b0 || fwd_hit !== 2'b10 || op_data[63:32] !== stage_data[63:32]) begin
         n_err++;
         $display("FAIL load_use_fwd: stall=%b hit=%b data1=%h want 0 10 %h",
                  dec_stall, fwd_hit, op_data[63:32], stage_data[63:32]);
      end
      tick();
      clean();
   endtask

   task automatic test_youngest();
      issue(5'd3, 2'd0);
      tick();
      issue(5'd3, 2'd0);
      tick();
      idle();
      dec_valid = 1;
      dec_rs_addr = {5'd0, 5'd3};
      stage_data[31:0]  = 32'hA;
      stage_data[63:32] = 32'hB;
      #1;
      n_cmp++;
      if (op_data[31:0] !== 32'hA || fwd_hit !== 2'b01) begin
         n_err++;
         $display("FAIL youngest: data0=%h hit=%b want a 01", op_data[31:0], fwd_hit);
      end
      tick();
      clean();
   endtask

   task automatic test_x0_kill();
      issue(5'd0, 2'd0);
      tick();
      issue(5'd9, 2'd0);
      dec_kill = 1;
      tick();
      idle();
      dec_valid = 1;
      dec_rs_addr = {5'd9, 5'd0};
      #1;
      n_cmp++;
      if (dec_stall !== 1'b0 || fwd_hit !== 2'b00 || op_data !== rf_rs_data) begin
         n_err++;
         $display("FAIL x0_kill: stall=%b hit=%b data=%h want 0 00 %h",
                  dec_stall, fwd_hit, op_data, rf_rs_data);
      end
      tick();
      clean();
   endtask

   task automatic test_freeze_flush();
      issue(5'd4, 2'd1);
      tick();
      idle();
      freeze = 1;
      dec_valid = 1; dec_wen = 1; dec_rd = 5'd6;
      dec_rs_addr = {5'd0, 5'd4};
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if (dec_stall !== 1'b1) begin
            n_err++;
            $display("FAIL freeze_stall[%0d]: stall=%b want 1", c, dec_stall);
         end
         tick();
      end
      flush = 1;
      tick();
      idle();
      dec_valid = 1;
      dec_rs_addr = {5'd4, 5'd4};
      #1;
      n_cmp++;
      if (dec_stall !== 1'b0 || fwd_hit !== 2'b00 || op_data !== rf_rs_data) begin
         n_err++;
         $display("FAIL after_flush: stall=%b hit=%b data=%h want 0 00 %h",
                  dec_stall, fwd_hit, op_data, rf_rs_data);
      end
      tick();
      clean();
   endtask

   task automatic test_async_reset();
      issue(5'd10, 2'd0);
      tick();
      issue(5'd11, 2'd0);
      tick();
      issue(5'd12, 2'd1);
      tick();
      idle();
      dec_valid = 1;
      dec_rs_addr = {5'd12, 5'd11};
      #1;
      n_cmp++;
      if (dec_stall !== 1'b1 || fwd_hit !== 2'b01 || op_data[31:0] !== stage_data[63:32]) begin
         n_err++;
         $display("FAIL pre_async: stall=%b hit=%b data0=%h want 1 01 %h",
                  dec_stall, fwd_hit, op_data[31:0], stage_data[63:32]);
      end
      #2;
      rst = 1;
      #1;
      n_cmp++;
      if (dec_stall !== 1'b0 || fwd_hit !== 2'b00 || op_data !== rf_rs_data) begin
         n_err++;
         $display("FAIL async_reset: stall=%b hit=%b data=%h want 0 00 %h",
                  dec_stall, fwd_hit, op_data, rf_rs_data);
      end
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      idle();
   endtask

   task automatic test_random();
      logic        e_stall;
      logic [1:0]  e_hit;
      logic [63:0] e_data;
      for (int c = 0; c < 400; c++) begin
         dec_valid   = ($urandom_range(0, 3) != 0);
         dec_wen     = ($urandom_range(0, 3) != 0);
         dec_rd      = 5'($urandom_range(0, 7));
         dec_lat     = 2'($urandom_range(0, 2));
         dec_rs_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         dec_kill    = ($urandom_range(0, 7) == 0);
         freeze      = ($urandom_range(0, 7) == 0);
         flush       = ($urandom_range(0, 31) == 0);
         rf_rs_data  = {$urandom, $urandom};
         stage_data  = {$urandom, $urandom, $urandom};
         #1;
         model_eval(e_stall, e_hit, e_data);
         n_cmp++;
         if (dec_stall !== e_stall || fwd_hit !== e_hit || op_data !== e_data) begin
            n_err++;
            $display("FAIL random[%0d]: stall=%b hit=%b data=%h want %b %b %h",
                     c, dec_stall, fwd_hit, op_data, e_stall, e_hit, e_data);
         end
         tick();
      end
      idle();
`ifdef BYPASS_STATS_EN
      n_cmp++;
      if (stat_stall_cnt !== 32'(m_stall_cnt) || stat_fwd_cnt !== 32'(m_fwd_cnt)) begin
         n_err++;
         $display("FAIL stats: stall_cnt=%0d fwd_cnt=%0d want %0d %0d",
                  stat_stall_cnt, stat_fwd_cnt, m_stall_cnt, m_fwd_cnt);
      end
`endif
   endtask

   initial begin
      model_reset();
      test_reset();
      test_alu_b2b();
      test_load_use();
      test_youngest();
      test_x0_kill();
      test_freeze_flush();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
